// File: rtl/key_press_classifier.sv
// ---------------------------------------------------------------------------
// key_press_classifier
//
// Classifies debounced key gestures (from key_filter) into short press,
// long press and double click, emitting one single-cycle pulse per gesture.
// Optionally emits auto-repeat pulses while a long press is held.
//
// Build option:
//   KEY_REPEAT_EN - when defined, HOLD runs a repeat counter and key_repeat
//                   pulses every REPEAT_CNT cycles; when undefined key_repeat
//                   is constant 0 and HOLD only waits for the release.
//
// Parameters:
//   LONG_CNT   - hold cycles that make a press "long"
//   DBL_CNT    - max release-to-second-press gap for a double click
//   REPEAT_CNT - auto-repeat period in cycles
//   CW         - counter width, 2**CW > max(LONG_CNT, DBL_CNT, REPEAT_CNT)
//
// Ports:
//   clk          - system clock
//   rst          - asynchronous reset, active low
//   key_flag     - one-cycle pulse on each debounced edge
//   key_state    - debounced level, 0 = pressed, 1 = released
//   short_press  - one-cycle pulse, short press recognised
//   long_press   - one-cycle pulse, long press recognised
//   double_click - one-cycle pulse, double click recognised
//   key_repeat   - one-cycle pulse per repeat period while held
//   busy         - high while the classifier is not idle
// ---------------------------------------------------------------------------
module key_press_classifier #(
    parameter int LONG_CNT   = 50_000_000,
    parameter int DBL_CNT    = 12_500_000,
    parameter int REPEAT_CNT = 5_000_000,
    parameter int CW         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic key_repeat,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_CNT - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CNT - 1);
`endif

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          press_s;
    logic          release_s;

    // Edge decoding of the debouncer handshake
    assign press_s   = key_flag & ~key_state;
    assign release_s = key_flag &  key_state;

    // Gesture FSM with shared counter and registered event outputs.
    // Edge events are checked before terminal counts so that an edge in
    // the same cycle as a timeout wins. Edges that make no sense in the
    // current state fall through to the normal counting path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            key_repeat   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            key_repeat   <= 1'b0;
            busy         <= (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (press_s) begin
                        state_r <= PRESS1;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r;
                        busy    <= 1'b0;
                    end
                end
                PRESS1: begin
                    if (release_s) begin
                        state_r <= WAIT2;
                        cnt_r   <= '0;
                    end else if (cnt_r == LONG_LAST) begin
                        long_press <= 1'b1;
                        state_r    <= HOLD;
                        cnt_r      <= '0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                WAIT2: begin
                    if (press_s) begin
                        state_r <= PRESS2;
                        cnt_r   <= '0;
                    end else if (cnt_r == DBL_LAST) begin
                        short_press <= 1'b1;
                        state_r     <= IDLE;
                        cnt_r       <= '0;
                        busy        <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                PRESS2: begin
                    // No timeout here: the second press may be held freely
                    if (release_s) begin
                        double_click <= 1'b1;
                        state_r      <= IDLE;
                        cnt_r        <= '0;
                        busy         <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                HOLD: begin
                    if (release_s) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        busy    <= 1'b0;
                    end else begin
`ifdef KEY_REPEAT_EN
                        if (cnt_r == REP_LAST) begin
                            key_repeat <= 1'b1;
                            cnt_r      <= '0;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
`else
                        cnt_r <= cnt_r;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_key_press_classifier
//
// Directed bench for key_press_classifier with LONG_CNT=100, DBL_CNT=40,
// REPEAT_CNT=10. A negedge monitor counts output pulses and time-stamps
// them with the index of the clock edge that produced them; the directed
// sequence compares counts and timestamps against hand-derived values.
// ---------------------------------------------------------------------------
module tb_key_press_classifier;

    localparam int LONG_CNT   = 100;
    localparam int DBL_CNT    = 40;
    localparam int REPEAT_CNT = 10;

    logic clk = 1'b0;
    logic rst;
    logic key_flag;
    logic key_state;
    logic short_press;
    logic long_press;
    logic double_click;
    logic key_repeat;
    logic busy;

    key_press_classifier #(
        .LONG_CNT  (LONG_CNT),
        .DBL_CNT   (DBL_CNT),
        .REPEAT_CNT(REPEAT_CNT),
        .CW        (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .key_repeat  (key_repeat),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge N, cyc == N
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor
    int n_short = 0, n_long = 0, n_dbl = 0, n_rep = 0, n_multi = 0;
    int e_short = -1, e_long = -1, e_dbl = -1;
    int rep_q[$];
    always @(negedge clk) begin
        if (short_press === 1'b1) begin n_short <= n_short + 1; e_short <= cyc; end
        if (long_press === 1'b1) begin n_long <= n_long + 1; e_long <= cyc; end
        if (double_click === 1'b1) begin n_dbl <= n_dbl + 1; e_dbl <= cyc; end
        if (key_repeat === 1'b1) begin n_rep <= n_rep + 1; rep_q.push_back(cyc); end
        if ((int'(short_press) + int'(long_press) + int'(double_click) + int'(key_repeat)) > 1)
            n_multi <= n_multi + 1;
    end

    int n_pass = 0;
    int n_total = 0;
    int b_short, b_long, b_dbl, b_rep;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic snap();
        b_short = n_short;
        b_long  = n_long;
        b_dbl   = n_dbl;
        b_rep   = n_rep;
    endtask

    // Called 1 time unit after a posedge; the flag is sampled at the next
    // posedge whose index is returned in e.
    task automatic edge_ev(input logic st, output int e);
        key_state = st;
        key_flag  = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        key_flag = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int p, r, p2, r2, x, idx;

    initial begin
        rst       = 1'b0;
        key_flag  = 1'b0;
        key_state = 1'b1;
        wait_cyc(3);
        chk("reset_short",  short_press,  1'b0);
        chk("reset_long",   long_press,   1'b0);
        chk("reset_dbl",    double_click, 1'b0);
        chk("reset_repeat", key_repeat,   1'b0);
        chk("reset_busy",   busy,         1'b0);
        rst = 1'b1;
        wait_cyc(2);

        // Short press: release 20 cycles after press
        snap();
        edge_ev(1'b0, p);
        chk("short_busy_hi", busy, 1'b1);
        wait_cyc(19);
        edge_ev(1'b1, r);
        wait_cyc(60);
        chk("short_count", n_short - b_short, 1);
        chk("short_time",  e_short, r + DBL_CNT);
        chk("short_nolong", n_long - b_long, 0);
        chk("short_nodbl",  n_dbl - b_dbl, 0);
        chk("short_busy_lo", busy, 1'b0);

        // Long press held 135 cycles
        snap();
        edge_ev(1'b0, p);
        wait_cyc(134);
        edge_ev(1'b1, r);
        wait_cyc(60);
        chk("long_count", n_long - b_long, 1);
        chk("long_time",  e_long, p + LONG_CNT);
        chk("long_noshort", n_short - b_short, 0);
`ifdef KEY_REPEAT_EN
        chk("repeat_count", n_rep - b_rep, 3);
        for (int i = 0; i < 3; i++) begin
            idx = b_rep + i;
            chk("repeat_time", (rep_q.size() > idx) ? rep_q[idx] : -1,
                e_long + (i + 1) * REPEAT_CNT);
        end
`else
        chk("repeat_none", n_rep - b_rep, 0);
`endif
        chk("long_busy_lo", busy, 1'b0);

        // Double click
        snap();
        edge_ev(1'b0, p);
        wait_cyc(9);
        edge_ev(1'b1, r);
        wait_cyc(14);
        edge_ev(1'b0, p2);
        wait_cyc(4);
        edge_ev(1'b1, r2);
        chk("dbl_pulse_now", double_click, 1'b1);
        wait_cyc(60);
        chk("dbl_count", n_dbl - b_dbl, 1);
        chk("dbl_time",  e_dbl, r2);
        chk("dbl_noshort", n_short - b_short, 0);

        // Boundary: release exactly when PRESS1 count reaches LONG_CNT-1
        snap();
        edge_ev(1'b0, p);
        wait_cyc(LONG_CNT - 1);
        edge_ev(1'b1, r);
        wait_cyc(60);
        chk("bnd_rel_nolong", n_long - b_long, 0);
        chk("bnd_rel_short",  n_short - b_short, 1);
        chk("bnd_rel_time",   e_short, r + DBL_CNT);

        // Boundary: second press exactly when WAIT2 count reaches DBL_CNT-1
        snap();
        edge_ev(1'b0, p);
        wait_cyc(9);
        edge_ev(1'b1, r);
        wait_cyc(DBL_CNT - 1);
        edge_ev(1'b0, p2);
        chk("bnd_press_noshort_now", short_press, 1'b0);
        wait_cyc(4);
        edge_ev(1'b1, r2);
        wait_cyc(60);
        chk("bnd_press_dbl",     n_dbl - b_dbl, 1);
        chk("bnd_press_noshort", n_short - b_short, 0);

        // Reset 50 cycles into PRESS1
        snap();
        edge_ev(1'b0, p);
        wait_cyc(49);
        rst = 1'b0;
        #1;
        chk("rstmid_busy",  busy,         1'b0);
        chk("rstmid_short", short_press,  1'b0);
        chk("rstmid_long",  long_press,   1'b0);
        chk("rstmid_dbl",   double_click, 1'b0);
        chk("rstmid_rep",   key_repeat,   1'b0);
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(150);
        chk("rstmid_noevents", (n_short - b_short) + (n_long - b_long) +
                               (n_dbl - b_dbl) + (n_rep - b_rep), 0);
        chk("rstmid_idle", busy, 1'b0);
        // Release of the key still held across reset lands in IDLE
        edge_ev(1'b1, x);
        wait_cyc(2);
        chk("rstmid_rel_ignored", busy, 1'b0);
        snap();
        edge_ev(1'b0, p);
        wait_cyc(19);
        edge_ev(1'b1, r);
        wait_cyc(60);
        chk("after_rst_short", n_short - b_short, 1);
        chk("after_rst_time",  e_short, r + DBL_CNT);

        // Spurious edges: release in IDLE, press during PRESS1
        snap();
        edge_ev(1'b1, x);
        chk("spur_idle_busy", busy, 1'b0);
        edge_ev(1'b0, p);
        wait_cyc(29);
        edge_ev(1'b0, x);
        chk("spur_press1_busy", busy, 1'b1);
        wait_cyc(19);
        edge_ev(1'b1, r);
        wait_cyc(60);
        chk("spur_short_time", e_short, r + DBL_CNT);
        chk("spur_short_cnt",  n_short - b_short, 1);
        chk("spur_nolong",     n_long - b_long, 0);

        // Spurious press mid-PRESS1 must not shift long-press timing
        snap();
        edge_ev(1'b0, p);
        wait_cyc(49);
        edge_ev(1'b0, x);
        wait_cyc(60);
        chk("spur_long_cnt",  n_long - b_long, 1);
        chk("spur_long_time", e_long, p + LONG_CNT);
        edge_ev(1'b1, r);
        wait_cyc(5);
        chk("spur_long_idle", busy, 1'b0);

        chk("one_hot_outputs", n_multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
